// File: rtl/onehot_seq_checker_if.sv
// rtl/onehot_seq_checker_if.sv - code stream and status bundle for the one-hot ring sequence checker
interface onehot_seq_checker_if;
    logic       valid_in;
    logic [3:0] code_in;
    logic [1:0] state;
    logic       locked;
    logic [1:0] idx;
    logic [7:0] seg;
    logic       err;
    logic [3:0] err_cnt;

    modport master (
        output valid_in,
        output code_in,
        input  state,
        input  locked,
        input  idx,
        input  seg,
        input  err,
        input  err_cnt
    );

    modport slave (
        input  valid_in,
        input  code_in,
        output state,
        output locked,
        output idx,
        output seg,
        output err,
        output err_cnt
    );
endinterface

// File: rtl/onehot_seq_checker.sv
// rtl/onehot_seq_checker.sv - tracks a rotating one-hot code, declares lock after LOCK_N good steps
module onehot_seq_checker #(
    parameter int LOCK_N = 4
) (
    input  logic                  clk_2,
    input  logic                  reset,
    onehot_seq_checker_if.slave   bus
);

    localparam logic [1:0] HUNT   = 2'b00;
    localparam logic [1:0] TRACK  = 2'b01;
    localparam logic [1:0] LOCKED = 2'b10;
    localparam logic [7:0] SEG_DASH = 8'b0100_0000;

    logic [1:0] state_q, state_d;
    logic [3:0] code_q, code_d;
    logic [1:0] idx_q, idx_d;
    logic [2:0] good_cnt_q, good_cnt_d;
    logic       err_q, err_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic       locked_q, locked_d;
    logic [7:0] seg_q, seg_d;

    logic       legal;
    logic       match;
    logic       mismatch;
    logic [3:0] expected;
    logic [1:0] code_idx;
    logic [3:0] good_inc;

    assign legal    = (bus.code_in != 4'b0000) && ((bus.code_in & (bus.code_in - 4'd1)) == 4'b0000);
    assign expected = {code_q[2:0], code_q[3]};
    assign match    = (bus.code_in == expected);
    assign good_inc = {1'b0, good_cnt_q} + 4'd1;

    always_comb begin
        code_idx = 2'd0;
        if (bus.code_in[1]) code_idx = 2'd1;
        if (bus.code_in[2]) code_idx = 2'd2;
        if (bus.code_in[3]) code_idx = 2'd3;
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q    <= HUNT;
            code_q     <= 4'b0001;
            idx_q      <= 2'd0;
            good_cnt_q <= 3'd0;
            err_q      <= 1'b0;
            err_cnt_q  <= 4'd0;
            locked_q   <= 1'b0;
            seg_q      <= SEG_DASH;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            idx_q      <= idx_d;
            good_cnt_q <= good_cnt_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            locked_q   <= locked_d;
            seg_q      <= seg_d;
        end
    end

    // A mismatch only drops back to HUNT; the offending code is never reused as a seed.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        idx_d      = idx_q;
        good_cnt_d = good_cnt_q;
        mismatch   = 1'b0;
        case (state_q)
            HUNT: begin
                if (bus.valid_in && legal) begin
                    state_d    = TRACK;
                    code_d     = bus.code_in;
                    idx_d      = code_idx;
                    good_cnt_d = 3'd0;
                end
            end
            TRACK: begin
                if (bus.valid_in) begin
                    if (match) begin
                        code_d     = bus.code_in;
                        idx_d      = code_idx;
                        good_cnt_d = good_inc[2:0];
                        if (good_inc == 4'(LOCK_N)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        mismatch   = 1'b1;
                        state_d    = HUNT;
                        good_cnt_d = 3'd0;
                    end
                end
            end
            LOCKED: begin
                if (bus.valid_in) begin
                    if (match) begin
                        code_d = bus.code_in;
                        idx_d  = code_idx;
                    end else begin
                        mismatch   = 1'b1;
                        state_d    = HUNT;
                        good_cnt_d = 3'd0;
                    end
                end
            end
            default: begin
                state_d    = HUNT;
                good_cnt_d = 3'd0;
            end
        endcase
    end

    always_comb begin
        err_d     = mismatch;
        err_cnt_d = err_cnt_q;
        if (mismatch && (err_cnt_q != 4'd15)) begin
            err_cnt_d = err_cnt_q + 4'd1;
        end
        locked_d = (state_d == LOCKED);
        seg_d    = SEG_DASH;
        if (locked_d) begin
            case (idx_d)
                2'd0:    seg_d = 8'b0011_1111;
                2'd1:    seg_d = 8'b0000_0110;
                2'd2:    seg_d = 8'b0101_1011;
                default: seg_d = 8'b0100_1111;
            endcase
        end
    end

    assign bus.state   = state_q;
    assign bus.locked  = locked_q;
    assign bus.idx     = idx_q;
    assign bus.seg     = seg_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_onehot_seq_checker.sv
// tb/tb_onehot_seq_checker.sv - directed bench for onehot_seq_checker with a reference model
module tb_onehot_seq_checker;

    localparam int LOCK_N = 4;

    logic clk_2 = 1'b0;
    logic reset = 1'b1;

    onehot_seq_checker_if bus_if ();

    onehot_seq_checker #(.LOCK_N(LOCK_N)) dut (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk_2 = ~clk_2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position on the ring, run length, error tally.
    int  m_state = 0;
    int  m_idx   = 0;
    int  m_run   = 0;
    int  m_err   = 0;
    int  m_ecnt  = 0;
    bit  model_on = 1'b0;
    int  digits [4] = '{8'h3F, 8'h06, 8'h5B, 8'h4F};

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int ones(input logic [3:0] c);
        int n = 0;
        for (int i = 0; i < 4; i++) if (c[i]) n++;
        return n;
    endfunction

    function automatic int pos_of(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (c[i]) return i;
        return 0;
    endfunction

    task automatic model_update(input logic v, input logic [3:0] c, input logic r);
        int nxt;
        bit ok;
        if (r) begin
            m_state = 0; m_idx = 0; m_run = 0; m_err = 0; m_ecnt = 0;
            return;
        end
        m_err = 0;
        if (!v) return;
        nxt = (m_idx + 1) % 4;
        ok  = (ones(c) == 1) && (pos_of(c) == nxt);
        if (m_state == 0) begin
            if (ones(c) == 1) begin
                m_idx = pos_of(c); m_run = 0; m_state = 1;
            end
        end else if (ok) begin
            m_idx = nxt;
            if (m_state == 1) begin
                m_run++;
                if (m_run == LOCK_N) m_state = 2;
            end
        end else begin
            m_err = 1;
            if (m_ecnt < 15) m_ecnt++;
            m_state = 0;
            m_run = 0;
        end
    endtask

    always @(negedge clk_2) begin
        if (model_on) begin
            chk("m_state",   int'(bus_if.state),   m_state);
            chk("m_locked",  int'(bus_if.locked),  (m_state == 2) ? 1 : 0);
            chk("m_idx",     int'(bus_if.idx),     m_idx);
            chk("m_seg",     int'(bus_if.seg),     (m_state == 2) ? digits[m_idx] : 8'h40);
            chk("m_err",     int'(bus_if.err),     m_err);
            chk("m_err_cnt", int'(bus_if.err_cnt), m_ecnt);
        end
    end

    task automatic step(input logic v, input logic [3:0] c, input logic r);
        @(negedge clk_2);
        bus_if.valid_in = v;
        bus_if.code_in  = c;
        reset           = r;
        @(posedge clk_2);
        model_update(v, c, r);
        if (r) model_on = 1'b1;
        #1;
    endtask

    task automatic lock_up();
        logic [3:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq[i], 1'b0);
            chk("lock_err_low", int'(bus_if.err), 0);
            if (i == 0) chk("lock_track_first", int'(bus_if.state), 1);
            if (i == 3) chk("lock_not_yet", int'(bus_if.locked), 0);
        end
    endtask

    initial begin
        bus_if.valid_in = 1'b0;
        bus_if.code_in  = 4'b0000;
        step(1'b0, 4'b0000, 1'b1);
        step(1'b1, 4'b0001, 1'b1);
        chk("rst_state", int'(bus_if.state), 0);
        chk("rst_idx", int'(bus_if.idx), 0);
        chk("rst_seg", int'(bus_if.seg), 8'h40);
        chk("rst_err_cnt", int'(bus_if.err_cnt), 0);

        lock_up();
        chk("lock_locked", int'(bus_if.locked), 1);
        chk("lock_idx", int'(bus_if.idx), 0);
        chk("lock_seg", int'(bus_if.seg), 8'h3F);

        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        step(1'b1, 4'b1000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0110, 1'b0);
            chk("gap_state", int'(bus_if.state), 2);
            chk("gap_idx", int'(bus_if.idx), 3);
        end
        step(1'b1, 4'b0001, 1'b0);
        chk("wrap_idx", int'(bus_if.idx), 0);
        chk("wrap_locked", int'(bus_if.locked), 1);

        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b1000, 1'b0);
        chk("mm_err", int'(bus_if.err), 1);
        chk("mm_err_cnt", int'(bus_if.err_cnt), 1);
        chk("mm_locked", int'(bus_if.locked), 0);
        chk("mm_state", int'(bus_if.state), 0);
        chk("mm_seg", int'(bus_if.seg), 8'h40);
        chk("mm_idx", int'(bus_if.idx), 1);
        step(1'b1, 4'b0001, 1'b0);
        chk("mm_err_once", int'(bus_if.err), 0);
        chk("reseed_state", int'(bus_if.state), 1);
        chk("reseed_idx", int'(bus_if.idx), 0);

        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        chk("ill_track_err", int'(bus_if.err), 1);
        chk("ill_track_cnt", int'(bus_if.err_cnt), 2);
        step(1'b1, 4'b0000, 1'b0);
        chk("ill_hunt0_err", int'(bus_if.err), 0);
        step(1'b1, 4'b0110, 1'b0);
        chk("ill_hunt6_err", int'(bus_if.err), 0);
        chk("ill_hunt_state", int'(bus_if.state), 0);
        chk("ill_hunt_cnt", int'(bus_if.err_cnt), 2);

        lock_up();
        step(1'b1, 4'b0100, 1'b1);
        chk("rp_state", int'(bus_if.state), 0);
        chk("rp_err", int'(bus_if.err), 0);
        chk("rp_err_cnt", int'(bus_if.err_cnt), 0);
        step(1'b0, 4'b0000, 1'b0);
        chk("rp_no_incr", int'(bus_if.err_cnt), 0);

        begin
            int pulses = 0;
            for (int i = 0; i < 17; i++) begin
                step(1'b1, 4'b0001, 1'b0);
                chk("sat_seed_err", int'(bus_if.err), 0);
                step(1'b1, 4'b0001, 1'b0);
                if (bus_if.err) pulses++;
            end
            chk("sat_pulses", pulses, 17);
            chk("sat_err_cnt", int'(bus_if.err_cnt), 15);
        end
        step(1'b0, 4'b0000, 1'b0);
        chk("sat_hold", int'(bus_if.err_cnt), 15);

        @(negedge clk_2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
